ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Sixteen-master AHB bus arbiter: picks one requesting master per bus handover with a round-robin policy, honours locked transfers and split-masked masters, and drives the one-hot grant vector plus the data-phase master number and lock indication. It sits between the AHB masters' request/lock lines and the bus multiplexers, which steer address and write data using HMASTER.

## Interface
- No parameters; fixed at 16 masters, 4-bit master number.
- HCLK  in  1  bus clock; all state changes on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HBUSREQx  in  16  bit i = master i requests the bus.
- HLOCKx  in  16  bit i = master i wants a locked (indivisible) sequence.
- HGRANTx  out  16  one-hot grant; bit i = master i owns the next address phase.
- HSPLIT  in  16  bit i = master i is split by a slave; excluded from arbitration while high.
- HREADY  in  1  bus transfer complete; handover and HMASTER updates only when high.
- HMASTER  out  4  number of the master owning the current address phase.
- HMASTLOCK  out  1  current address phase is part of a locked sequence.

## Operation
- State: gnt_idx (4 b), gnt_valid (1 b), rr_ptr (4 b, last granted index), HMASTER reg, HMASTLOCK reg.
- Eligible master i: HBUSREQx[i]=1 and HSPLIT[i]=0.
- Next-owner selection (combinational): scan indices rr_ptr+1, rr_ptr+2, ... modulo 16 (wrap 15 -> 0); first eligible index wins. None eligible -> no owner.
- Lock hold: if gnt_valid, HLOCKx[gnt_idx]=1, HBUSREQx[gnt_idx]=1 and HSPLIT[gnt_idx]=0, the current owner is kept regardless of other requests.
- HSPLIT[gnt_idx]=1 overrides lock: owner released at the next HREADY edge.
- HGRANTx[i] = gnt_valid & (gnt_idx==i) & HBUSREQx[i] (combinational qualification); never more than one bit set; never set for a non-requesting master.
- No requester: HGRANTx=0, gnt_valid=0, HMASTER holds its last value.
- rr_ptr updates to the new gnt_idx whenever a new owner is selected; it is not changed while lock-hold keeps the owner or no owner exists.

## Timing
- Reset (async assert, any cycle, mid-transfer included): HGRANTx=0, HMASTER=0, HMASTLOCK=0, gnt_valid=0, rr_ptr=15 (so master 0 has first priority).
- Rising HCLK with HREADY=1: gnt_idx/gnt_valid <= arbitration result (lock-hold or round-robin); HMASTER <= previous gnt_idx if previous gnt_valid; HMASTLOCK <= previous gnt_valid & HLOCKx[previous gnt_idx].
- Rising HCLK with HREADY=0: all registers hold; grant cannot move during wait states.
- Latency: request at edge N (HREADY=1, bus free) -> HGRANTx set after edge N+1 -> HMASTER shows the master after the next HREADY edge (one address phase after grant).
- HGRANTx bit drops in the same cycle its HBUSREQx drops (combinational); registered owner is cleared at the next HREADY edge.
- Simultaneous requests: round-robin order decides; fairness guarantees every continuously eligible, requesting master is granted within 16 handovers absent locks.

## Test plan
- Reset: HRESETn=0 with arbitrary inputs -> HGRANTx=0x0000, HMASTER=0, HMASTLOCK=0, asynchronously; release, no requests -> outputs stay 0.
- Single request: HBUSREQx=0x0008, HREADY=1 -> HGRANTx=0x0008 after one edge, HMASTER=3 one edge later; drop request -> HGRANTx=0x0000 same cycle.
- Round-robin: HBUSREQx=0xFFFF held, HREADY=1 -> grants 0x0001,0x0002,...,0x8000, then wrap to 0x0001; $countones(HGRANTx)<=1 every cycle.
- Wait states: grant on master 2, others requesting, HREADY=0 for 5 cycles -> HGRANTx and HMASTER frozen; resumes rotation on HREADY=1.
- Lock: master 4 granted with HLOCKx[4]=1, HBUSREQx=0x0031 -> grant stays 0x0010, HMASTLOCK=1 with HMASTER=4; deassert HLOCKx[4] -> next grant 0x0020.
- Split: HBUSREQx=0x0006, HSPLIT=0x0002 -> only 0x0004 granted; clear HSPLIT -> master 1 granted in rotation.

Source files
------------

// File: rtl/ahb_arbiter.sv
// Sixteen-master AHB arbiter: round-robin handover with lock hold and split masking.
// Grant is qualified combinationally by the live request; owner and data-phase master are registered.
module ahb_arbiter (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [15:0] HBUSREQx,
   input  logic [15:0] HLOCKx,
   input  logic [15:0] HSPLIT,
   input  logic        HREADY,
   output logic [15:0] HGRANTx,
   output logic [3:0]  HMASTER,
   output logic        HMASTLOCK
);

   localparam int unsigned N_MST = 16;
   localparam int unsigned IDX_W = 4;

   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic [IDX_W-1:0] rr_ptr;

   logic [N_MST-1:0] eligible;
   logic             lock_hold;
   logic             rr_found;
   logic [IDX_W-1:0] rr_idx;
   logic [IDX_W-1:0] cand;
   logic [N_MST-1:0] grant_mask;

   assign eligible  = HBUSREQx & ~HSPLIT;
   assign lock_hold = gnt_valid & HLOCKx[gnt_idx] & HBUSREQx[gnt_idx] & ~HSPLIT[gnt_idx];

   // Scan from the slot after the last winner; the last winner itself is checked last.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = rr_ptr;
      cand     = '0;
      for (int unsigned k = 1; k <= N_MST; k++) begin
         cand = rr_ptr + IDX_W'(k);
         if (!rr_found && eligible[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
      end
   end

   assign grant_mask = N_MST'(1) << gnt_idx;
   assign HGRANTx    = gnt_valid ? (HBUSREQx & grant_mask) : '0;

   // Everything advances only on completed transfers so the grant cannot move in wait states.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         rr_ptr    <= IDX_W'(N_MST - 1);
         HMASTER   <= '0;
         HMASTLOCK <= 1'b0;
      end else if (HREADY) begin
         if (gnt_valid) begin
            HMASTER <= gnt_idx;
         end
         HMASTLOCK <= gnt_valid & HLOCKx[gnt_idx];
         if (lock_hold) begin
            gnt_valid <= 1'b1;
         end else if (rr_found) begin
            gnt_idx   <= rr_idx;
            gnt_valid <= 1'b1;
            rr_ptr    <= rr_idx;
         end else begin
            gnt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, single request, rotation, wait states, lock and split.
module tb_ahb_arbiter;

   logic        HCLK;
   logic        HRESETn;
   logic [15:0] HBUSREQx;
   logic [15:0] HLOCKx;
   logic [15:0] HSPLIT;
   logic        HREADY;
   logic [15:0] HGRANTx;
   logic [3:0]  HMASTER;
   logic        HMASTLOCK;

   int tests_run;
   int tests_failed;

   ahb_arbiter dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HBUSREQx  (HBUSREQx),
      .HLOCKx    (HLOCKx),
      .HSPLIT    (HSPLIT),
      .HREADY    (HREADY),
      .HGRANTx   (HGRANTx),
      .HMASTER   (HMASTER),
      .HMASTLOCK (HMASTLOCK)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [15:0] gnt, input logic [3:0] mst,
                             input logic lck);
      check({tag, ".grant"}, HGRANTx, gnt);
      check({tag, ".master"}, 16'(HMASTER), 16'(mst));
      check({tag, ".mastlock"}, 16'(HMASTLOCK), 16'(lck));
   endtask

   task automatic do_reset();
      HRESETn  = 1'b0;
      HBUSREQx = '0;
      HLOCKx   = '0;
      HSPLIT   = '0;
      HREADY   = 1'b1;
      tick();
      HRESETn = 1'b1;
   endtask

   logic [15:0] exp_gnt;

   initial begin
      tests_run    = 0;
      tests_failed = 0;

      // Reset with busy inputs
      HRESETn  = 1'b0;
      HBUSREQx = 16'hFFFF;
      HLOCKx   = 16'hFFFF;
      HSPLIT   = 16'h0000;
      HREADY   = 1'b1;
      tick(); tick(); tick();
      check_outs("reset", 16'h0000, 4'd0, 1'b0);
      HBUSREQx = '0;
      HLOCKx   = '0;
      HRESETn  = 1'b1;
      tick(); tick();
      check_outs("idle", 16'h0000, 4'd0, 1'b0);

      // Single request on master 3
      HBUSREQx = 16'h0008;
      tick();
      check_outs("single1", 16'h0008, 4'd0, 1'b0);
      tick();
      check_outs("single2", 16'h0008, 4'd3, 1'b0);
      HBUSREQx = 16'h0000;
      #1;
      check("single_drop", HGRANTx, 16'h0000);
      tick(); tick();
      check_outs("single_idle", 16'h0000, 4'd3, 1'b0);

      // Full rotation with wrap
      do_reset();
      HBUSREQx = 16'hFFFF;
      for (int k = 0; k <= 16; k++) begin
         tick();
         exp_gnt = 16'h0001 << (k % 16);
         check("rr.grant", HGRANTx, exp_gnt);
         check("rr.onehot", 16'($countones(HGRANTx) <= 1), 16'd1);
         if (k >= 1) check("rr.master", 16'(HMASTER), 16'((k - 1) % 16));
      end

      // Wait states freeze grant on master 2
      tick();
      check("ws.pre1", HGRANTx, 16'h0002);
      tick();
      check_outs("ws.pre2", 16'h0004, 4'd1, 1'b0);
      HREADY = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_outs("ws.hold", 16'h0004, 4'd1, 1'b0);
      end
      HREADY = 1'b1;
      tick();
      check_outs("ws.resume", 16'h0008, 4'd2, 1'b0);

      // Locked sequence on master 4
      do_reset();
      HBUSREQx = 16'h0010;
      HLOCKx   = 16'h0010;
      tick();
      check("lock.grant0", HGRANTx, 16'h0010);
      HBUSREQx = 16'h0031;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_outs("lock.hold", 16'h0010, 4'd4, 1'b1);
      end
      HLOCKx = 16'h0000;
      tick();
      check_outs("lock.release", 16'h0020, 4'd4, 1'b0);

      // Split masking
      do_reset();
      HBUSREQx = 16'h0006;
      HSPLIT   = 16'h0002;
      tick();
      check("split.g1", HGRANTx, 16'h0004);
      tick();
      check("split.g2", HGRANTx, 16'h0004);
      HSPLIT = 16'h0000;
      tick();
      check("split.clear", HGRANTx, 16'h0002);
      tick();
      check("split.next", HGRANTx, 16'h0004);

      // Split overrides a lock on the owner
      HLOCKx = 16'h0004;
      tick();
      check("splitlock.hold", HGRANTx, 16'h0004);
      HSPLIT = 16'h0004;
      tick();
      check("splitlock.release", HGRANTx, 16'h0002);

      // Asynchronous reset in the middle of a cycle
      HSPLIT = 16'h0000;
      HLOCKx = 16'h0000;
      tick();
      check("async.pre", HGRANTx, 16'h0004);
      #2;
      HRESETn = 1'b0;
      #1;
      check_outs("async", 16'h0000, 4'd0, 1'b0);
      tick();
      HRESETn = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
